// File: rtl/ram_byte_seq_if.sv
// Load/store request and response bundle between the LSU and the byte RAM sequencer.
interface ram_byte_seq_if #(
  parameter int AW = 15
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ram_byte_seq.sv
// Splits 8/16/32-bit load/store requests into little-endian byte accesses on a
// byte-wide RAM and returns a single-cycle, extended response.
module ram_byte_seq #(
  parameter int AW               = 15,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  ram_byte_seq_if.slave bus,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [7:0]    ram_wdata,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  input  logic [7:0]    ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    k;
  logic          err_q;
  logic [31:0]   buf_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          hs;
  logic          last;
  logic [AW-1:0] byte_addr;

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = (size == 2'd3);
    if (!ALLOW_MISALIGNED && size == 2'd1 && lo[0]) bad = 1'b1;
    if (!ALLOW_MISALIGNED && size == 2'd2 && lo != 2'd0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      2'd0:    r = 2'd0;
      2'd1:    r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] size,
                                         input logic uns);
    logic [31:0] r;
    case (size)
      2'd0:    r = {{24{b[7] & ~uns}}, b[7:0]};
      2'd1:    r = {{16{b[15] & ~uns}}, b[15:0]};
      default: r = b;
    endcase
    return r;
  endfunction

  assign hs        = bus.req_valid && (state == IDLE) && !rst;
  assign last      = (k == last_idx(size_q));
  assign byte_addr = addr_q + AW'(k);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= 2'd0;
      buf_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        k     <= 2'd0;
        err_q <= req_bad(bus.req_size, bus.req_addr[1:0]);
      end else if (state == ACCESS) begin
        k <= k + 2'd1;
        if (!we_q) buf_q[{k, 3'b000} +: 8] <= ram_rdata;
      end
    end
  end

  // Request fields only matter after a handshake, so they carry no reset.
  always_ff @(posedge clk) begin
    if (hs) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'd0;
    ram_we         = 1'b0;
    ram_waddr      = '0;
    ram_wdata      = 8'd0;
    ram_re         = 1'b0;
    ram_raddr      = '0;
    case (state)
      IDLE: begin
        if (hs) state_nxt = req_bad(bus.req_size, bus.req_addr[1:0]) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (last) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
    // Everything visible is forced quiet while reset is held, including a mid-access abort.
    if (!rst) begin
      bus.req_ready = (state == IDLE);
      if (state == ACCESS) begin
        if (we_q) begin
          ram_we    = 1'b1;
          ram_waddr = byte_addr;
          ram_wdata = wdata_q[{k, 3'b000} +: 8];
        end else begin
          ram_re    = 1'b1;
          ram_raddr = byte_addr;
        end
      end
      if (state == RESP) begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (!err_q && !we_q) ? extend(buf_q, size_q, uns_q) : 32'd0;
      end
    end
  end

endmodule
